// File: rtl/cmd_pkt_to_regmap_if.sv
// Stream-in and regmap write-command bundle for cmd_pkt_to_regmap.
// master = packet source / regmap side, slave = the parser.
interface cmd_pkt_to_regmap_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        wr_cmd;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_keep;
  logic        wr_ready;
  logic        wr_valid;
  logic [1:0]  wr_err;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  wr_cmd,
    input  wr_addr,
    input  wr_data,
    input  wr_keep,
    output wr_ready,
    output wr_valid,
    output wr_err
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output wr_cmd,
    output wr_addr,
    output wr_data,
    output wr_keep,
    input  wr_ready,
    input  wr_valid,
    input  wr_err
  );
endinterface

// File: rtl/cmd_pkt_to_regmap.sv
// Parses register-write command packets off a byte stream and
// issues one regmap write per record, with packet/error statistics.
module cmd_pkt_to_regmap #(
  parameter logic [7:0] MAGIC       = 8'hC5,
  parameter int         MAX_RECORDS = 32,
  parameter int         ACK_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmd_pkt_to_regmap_if.slave   bus,
  output logic                 busy,
  output logic [15:0]          pkt_ok_cnt,
  output logic [15:0]          pkt_err_cnt,
  output logic [15:0]          wr_err_cnt
);

  localparam int RW = $clog2(MAX_RECORDS + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [8:0]    MAXR    = 9'(MAX_RECORDS);
  localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT,
    S_REC,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [RW-1:0] left_q, left_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sh_addr_q, sh_addr_d;
  logic [31:0] sh_data_q, sh_data_d;
  logic [31:0] sh_keep_q, sh_keep_d;
  logic        last_q, last_d;
  logic        cmd_q, cmd_d;
  logic [7:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] wk_q, wk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] ok_q, ok_d;
  logic [15:0] err_q, err_d;
  logic [15:0] werr_q, werr_d;

  logic       tready;
  logic       acc;
  logic       tlast;
  logic [7:0] tdata;
  logic       pkt_ok;
  logic       pkt_err;

  // tready stays low through reset and the first clock after release
  assign tready = rdy_q && (state_q != S_ISSUE);
  assign acc    = bus.s_axis_tvalid && tready;
  assign tlast  = bus.s_axis_tlast;
  assign tdata  = bus.s_axis_tdata;

  assign bus.s_axis_tready = tready;
  assign bus.wr_cmd        = cmd_q;
  assign bus.wr_addr       = wa_q;
  assign bus.wr_data       = wd_q;
  assign bus.wr_keep       = wk_q;

  assign busy        = (state_q != S_IDLE);
  assign pkt_ok_cnt  = ok_q;
  assign pkt_err_cnt = err_q;
  assign wr_err_cnt  = werr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      left_q    <= '0;
      idx_q     <= '0;
      sh_addr_q <= '0;
      sh_data_q <= '0;
      sh_keep_q <= '0;
      last_q    <= 1'b0;
      cmd_q     <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      wk_q      <= '0;
      tmo_q     <= '0;
      ok_q      <= '0;
      err_q     <= '0;
      werr_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      left_q    <= left_d;
      idx_q     <= idx_d;
      sh_addr_q <= sh_addr_d;
      sh_data_q <= sh_data_d;
      sh_keep_q <= sh_keep_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      wk_q      <= wk_d;
      tmo_q     <= tmo_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      werr_q    <= werr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rdy_d     = 1'b1;
    left_d    = left_q;
    idx_d     = idx_q;
    sh_addr_d = sh_addr_q;
    sh_data_d = sh_data_q;
    sh_keep_d = sh_keep_q;
    last_d    = last_q;
    cmd_d     = cmd_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    wk_d      = wk_q;
    tmo_d     = tmo_q;
    ok_d      = ok_q;
    err_d     = err_q;
    werr_d    = werr_q;
    pkt_ok    = 1'b0;
    pkt_err   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (tdata == MAGIC && !tlast) begin
            state_d = S_CNT;
          end else begin
            pkt_err = 1'b1;
            if (!tlast) state_d = S_DRAIN;
          end
        end
      end

      S_CNT: begin
        if (acc) begin
          if ({1'b0, tdata} > MAXR) begin
            pkt_err = 1'b1;
            state_d = tlast ? S_IDLE : S_DRAIN;
          end else if (tdata == 8'd0) begin
            if (tlast) begin
              pkt_ok  = 1'b1;
              state_d = S_IDLE;
            end else begin
              pkt_err = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (tlast) begin
            // records promised but packet already ended
            pkt_err = 1'b1;
            state_d = S_IDLE;
          end else begin
            left_d  = RW'(tdata);
            idx_d   = 4'd0;
            state_d = S_REC;
          end
        end
      end

      S_REC: begin
        if (acc) begin
          unique case (1'b1)
            (idx_q == 4'd0):
              sh_addr_d = tdata;
            (idx_q >= 4'd1 && idx_q <= 4'd4):
              sh_data_d = {sh_data_q[23:0], tdata};
            default:
              sh_keep_d = {sh_keep_q[23:0], tdata};
          endcase
          if (idx_q == 4'd8) begin
            last_d  = tlast;
            state_d = S_ISSUE;
          end else if (tlast) begin
            pkt_err = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      S_ISSUE: begin
        if (!cmd_q) begin
          if (bus.wr_ready) begin
            cmd_d = 1'b1;
            wa_d  = sh_addr_q;
            wd_d  = sh_data_q;
            wk_d  = sh_keep_q;
            tmo_d = '0;
          end
        end else if (bus.wr_valid) begin
          cmd_d = 1'b0;
          if (bus.wr_err != 2'b00) werr_d = werr_q + 16'd1;
          if (left_q != RW'(1)) begin
            if (last_q) begin
              pkt_err = 1'b1;
              state_d = S_IDLE;
            end else begin
              left_d  = left_q - RW'(1);
              idx_d   = 4'd0;
              state_d = S_REC;
            end
          end else if (last_q) begin
            pkt_ok  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pkt_err = 1'b1;
            state_d = S_DRAIN;
          end
        end else if (tmo_q == TMO_MAX) begin
          cmd_d   = 1'b0;
          pkt_err = 1'b1;
          state_d = last_q ? S_IDLE : S_DRAIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_DRAIN: begin
        if (acc && tlast) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (pkt_ok)  ok_d  = ok_q + 16'd1;
    if (pkt_err) err_d = err_q + 16'd1;
  end

endmodule

// File: tb/tb_cmd_pkt_to_regmap.sv
// Scoreboard bench for cmd_pkt_to_regmap: packets in, regmap writes
// checked against an expected-write queue, plus counter checks.
module tb_cmd_pkt_to_regmap;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] pkt_ok_cnt;
  logic [15:0] pkt_err_cnt;
  logic [15:0] wr_err_cnt;

  cmd_pkt_to_regmap_if bus_if();

  cmd_pkt_to_regmap dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .busy        (busy),
    .pkt_ok_cnt  (pkt_ok_cnt),
    .pkt_err_cnt (pkt_err_cnt),
    .wr_err_cnt  (wr_err_cnt)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  logic [71:0] exp_q[$];
  logic [7:0]  pk_q[$];
  int          wr_seen = 0;
  int          ack_n = 0;
  int          err_target = -1;
  bit          no_ack = 1'b0;
  int          age = 0;
  bit          prev_cmd = 1'b0;
  logic [71:0] held;

  int exp_ok   = 0;
  int exp_err  = 0;
  int exp_werr = 0;

  // regmap model and write monitor
  always @(negedge clk) begin
    logic [71:0] cur;
    logic [71:0] e;
    cur = {bus_if.wr_addr, bus_if.wr_data, bus_if.wr_keep};
    if (bus_if.wr_cmd) begin
      if (!prev_cmd) begin
        wr_seen++;
        asserts++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write got %h want none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL write_fields got %h want %h", cur, e);
          end
        end
      end else begin
        asserts++;
        if (cur !== held) begin
          fails++;
          $display("FAIL write_stable got %h want %h", cur, held);
        end
      end
      asserts++;
      if (bus_if.s_axis_tready !== 1'b0) begin
        fails++;
        $display("FAIL tready_in_issue got %b want 0",
                 bus_if.s_axis_tready);
      end
      held = cur;
    end
    prev_cmd = bus_if.wr_cmd;

    bus_if.wr_valid = 1'b0;
    bus_if.wr_err   = 2'b00;
    if (bus_if.wr_cmd && !no_ack) begin
      age++;
      if (age == 1) begin
        bus_if.wr_valid = 1'b1;
        ack_n++;
        if (ack_n == err_target) bus_if.wr_err = 2'b01;
      end
    end else begin
      age = 0;
    end
  end

  task automatic add_rec(input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] k, input bit exp_wr);
    pk_q.push_back(a);
    for (int i = 3; i >= 0; i--) pk_q.push_back(d[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) pk_q.push_back(k[i*8 +: 8]);
    if (exp_wr) exp_q.push_back({a, d, k});
  endtask

  task automatic put_byte(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_tdata  = d;
    bus_if.s_axis_tlast  = l;
    while (bus_if.s_axis_tready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      asserts++;
      fails++;
      $display("FAIL tready_wait got 0 want 1 within 2000 cycles");
    end
    @(posedge clk);
  endtask

  task automatic send_pkt();
    int n;
    n = pk_q.size();
    for (int i = 0; i < n; i++) put_byte(pk_q[i], i == n - 1);
    @(negedge clk);
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.s_axis_tlast  = 1'b0;
    pk_q.delete();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || bus_if.wr_cmd) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      asserts++;
      fails++;
      $display("FAIL idle_wait got busy want idle");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.s_axis_tdata  = 8'h00;
    bus_if.s_axis_tlast  = 1'b0;
    bus_if.wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    asserts++;
    if (bus_if.s_axis_tready !== 1'b0 || bus_if.wr_cmd !== 1'b0 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got tready=%b cmd=%b busy=%b want 0",
               bus_if.s_axis_tready, bus_if.wr_cmd, busy);
    end
    asserts++;
    if ({pkt_ok_cnt, pkt_err_cnt, wr_err_cnt} !== 48'd0 ||
        {bus_if.wr_addr, bus_if.wr_data, bus_if.wr_keep} !== 72'd0) begin
      fails++;
      $display("FAIL reset_data got %h %h want 0",
               {pkt_ok_cnt, pkt_err_cnt, wr_err_cnt},
               {bus_if.wr_addr, bus_if.wr_data, bus_if.wr_keep});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    asserts++;
    if (bus_if.s_axis_tready !== 1'b1) begin
      fails++;
      $display("FAIL tready_after_reset got %b want 1",
               bus_if.s_axis_tready);
    end
  endtask

  task automatic check_counts(input string tag);
    asserts++;
    if (pkt_ok_cnt !== 16'(exp_ok) || pkt_err_cnt !== 16'(exp_err) ||
        wr_err_cnt !== 16'(exp_werr)) begin
      fails++;
      $display("FAIL %s_counts got ok=%0d err=%0d werr=%0d want %0d %0d %0d",
               tag, pkt_ok_cnt, pkt_err_cnt, wr_err_cnt,
               exp_ok, exp_err, exp_werr);
    end
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_writes got %0d pending want 0",
               tag, exp_q.size());
    end
  endtask

  task automatic test_basic();
    pk_q = '{8'hC5, 8'h02};
    add_rec(8'h00, 32'h14, 32'hFFFFFFFF, 1'b1);
    add_rec(8'h01, 32'h15, 32'hFFFFFFFF, 1'b1);
    exp_ok++;
    send_pkt();
    wait_idle();
    check_counts("basic");
  endtask

  task automatic test_ready_stall();
    pk_q = '{8'hC5, 8'h02};
    add_rec(8'h10, 32'hDEADBEEF, 32'h0000FFFF, 1'b1);
    add_rec(8'h11, 32'h01234567, 32'hF0F0F0F0, 1'b1);
    exp_ok++;
    bus_if.wr_ready = 1'b0;
    fork
      send_pkt();
      begin
        repeat (60) @(negedge clk);
        asserts++;
        if (bus_if.wr_cmd !== 1'b0) begin
          fails++;
          $display("FAIL stall_cmd got %b want 0", bus_if.wr_cmd);
        end
        bus_if.wr_ready = 1'b1;
        @(posedge clk);
        #1;
        asserts++;
        if (bus_if.wr_cmd !== 1'b1) begin
          fails++;
          $display("FAIL stall_release got %b want 1", bus_if.wr_cmd);
        end
      end
    join
    wait_idle();
    check_counts("stall");
  endtask

  task automatic test_bad_magic();
    int w0;
    w0 = wr_seen;
    pk_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    exp_err++;
    send_pkt();
    wait_idle();
    asserts++;
    if (wr_seen != w0) begin
      fails++;
      $display("FAIL badmagic_writes got %0d want 0", wr_seen - w0);
    end
    check_counts("badmagic");
    pk_q = '{8'hC5, 8'h01};
    add_rec(8'h22, 32'hCAFEF00D, 32'hFFFF0000, 1'b1);
    exp_ok++;
    send_pkt();
    wait_idle();
    check_counts("after_badmagic");
  endtask

  task automatic test_truncated();
    int w0;
    w0 = wr_seen;
    pk_q = '{8'hC5, 8'h03};
    add_rec(8'h30, 32'h11111111, 32'h22222222, 1'b1);
    add_rec(8'h31, 32'h33333333, 32'h44444444, 1'b0);
    repeat (3) void'(pk_q.pop_back());
    exp_err++;
    send_pkt();
    wait_idle();
    asserts++;
    if (wr_seen - w0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL trunc_writes got %0d busy=%b want 1 busy=0",
               wr_seen - w0, busy);
    end
    check_counts("trunc");
  endtask

  task automatic test_record_count();
    int w0;
    w0 = wr_seen;
    pk_q = '{8'hC5, 8'h21, 8'h00, 8'h01, 8'h02};
    exp_err++;
    send_pkt();
    wait_idle();
    asserts++;
    if (wr_seen != w0) begin
      fails++;
      $display("FAIL n33_writes got %0d want 0", wr_seen - w0);
    end
    check_counts("n33");
    pk_q = '{8'hC5, 8'h00};
    exp_ok++;
    send_pkt();
    wait_idle();
    check_counts("n0_ok");
    pk_q = '{8'hC5, 8'h00, 8'hAA};
    exp_err++;
    send_pkt();
    wait_idle();
    check_counts("n0_long");
  endtask

  task automatic test_overlong();
    pk_q = '{8'hC5, 8'h01};
    add_rec(8'h40, 32'h89ABCDEF, 32'h000000FF, 1'b1);
    pk_q.push_back(8'h55);
    pk_q.push_back(8'h66);
    exp_err++;
    send_pkt();
    wait_idle();
    check_counts("overlong");
  endtask

  task automatic test_timeout();
    int guard;
    int hi;
    no_ack = 1'b1;
    pk_q = '{8'hC5, 8'h01};
    add_rec(8'h50, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b1);
    exp_err++;
    send_pkt();
    guard = 0;
    while (bus_if.wr_cmd !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    hi = 0;
    while (bus_if.wr_cmd === 1'b1 && hi < 1000) begin
      @(negedge clk);
      hi++;
    end
    asserts++;
    if (hi != 256) begin
      fails++;
      $display("FAIL timeout_len got %0d want 256", hi);
    end
    wait_idle();
    check_counts("timeout");
    no_ack = 1'b0;
  endtask

  task automatic test_wr_err();
    err_target = ack_n + 2;
    pk_q = '{8'hC5, 8'h02};
    add_rec(8'h60, 32'h00000001, 32'hFFFFFFFF, 1'b1);
    add_rec(8'h61, 32'h00000002, 32'hFFFFFFFF, 1'b1);
    exp_ok++;
    exp_werr++;
    send_pkt();
    wait_idle();
    check_counts("wrerr");
    err_target = -1;
  endtask

  task automatic test_reset_mid_write();
    int guard;
    no_ack = 1'b1;
    pk_q = '{8'hC5, 8'h01};
    add_rec(8'h70, 32'h77777777, 32'hFFFFFFFF, 1'b1);
    send_pkt();
    guard = 0;
    while (bus_if.wr_cmd !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if (bus_if.wr_cmd !== 1'b0 || bus_if.s_axis_tready !== 1'b0 ||
        busy !== 1'b0 || bus_if.wr_addr !== 8'h00) begin
      fails++;
      $display("FAIL midreset got cmd=%b rdy=%b busy=%b addr=%h want 0",
               bus_if.wr_cmd, bus_if.s_axis_tready, busy, bus_if.wr_addr);
    end
    exp_ok = 0;
    exp_err = 0;
    exp_werr = 0;
    check_counts("midreset");
    no_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pk_q = '{8'hC5, 8'h01};
    add_rec(8'h71, 32'h12345678, 32'h00FF00FF, 1'b1);
    exp_ok++;
    send_pkt();
    wait_idle();
    check_counts("resync");
  endtask

  initial begin
    bus_if.wr_valid = 1'b0;
    bus_if.wr_err = 2'b00;
    test_reset();
    test_basic();
    test_ready_stall();
    test_bad_magic();
    test_truncated();
    test_record_count();
    test_overlong();
    test_timeout();
    test_wr_err();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
